// File: rtl/dct_block_sched.sv
// dct_block_sched: frame-level scheduler for the 2-D DCT core.
// Fills a two-bank ping-pong input buffer from the loader stream, launches
// the core on each full bank, and releases the bank when the core reports done.
module dct_block_sched #(
    parameter int BPP    = 8,
    parameter int N      = 8,
    parameter int ADDR_W = 6,
    parameter int BLK_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BLK_W-1:0]  cfg_blocks,
    input  logic              frame_go,
    output logic              frame_busy,
    output logic              frame_done,
    input  logic              ld_valid,
    input  logic [BPP-1:0]    ld_data,
    output logic              ld_ready,
    output logic              buf_wr_en,
    output logic              buf_wr_bank,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [BPP-1:0]    buf_wr_data,
    output logic              dct_rd_bank,
    output logic              dct_start,
    input  logic              dct_ready,
    input  logic              dct_done,
    output logic [1:0]        bank_full,
    output logic [BLK_W-1:0]  blk_done_cnt,
    output logic              err_spurious_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);

    typedef enum logic {F_IDLE, F_RUN} frame_state_t;
    typedef enum logic {D_IDLE, D_WAIT} dct_state_t;

    frame_state_t      frame_q, frame_d;
    dct_state_t        dstate_q, dstate_d;
    logic [BLK_W-1:0]  cfg_q, cfg_d;
    logic [BLK_W-1:0]  loaded_q, loaded_d;
    logic [BLK_W-1:0]  done_q, done_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              frame_done_q, frame_done_d;
    logic              dct_start_q, dct_start_d;
    logic              err_q, err_d;

    logic              run_c;
    logic              ld_ready_c;
    logic              xfer_c;
    logic              last_c;
    logic              rel_c;
    logic [1:0]        set_mask_c;
    logic [1:0]        clr_mask_c;
    logic [BLK_W-1:0]  done_inc_c;

    // Handshake qualifiers shared by the load and DCT sides.
    always_comb begin
        run_c      = (frame_q == F_RUN);
        ld_ready_c = run_c && !bank_full_q[wr_bank_q] && (loaded_q < cfg_q);
        xfer_c     = ld_valid && ld_ready_c;
        last_c     = xfer_c && (wr_addr_q == LAST_ADDR);
        rel_c      = run_c && (dstate_q == D_WAIT) && dct_done;
        set_mask_c = last_c ? (2'b01 << wr_bank_q) : 2'b00;
        clr_mask_c = rel_c  ? (2'b01 << rd_bank_q) : 2'b00;
        done_inc_c = done_q + BLK_W'(1);
    end

    // Next-state logic for the frame FSM, load pointer and DCT sub-FSM.
    always_comb begin
        frame_d      = frame_q;
        dstate_d     = dstate_q;
        cfg_d        = cfg_q;
        loaded_d     = loaded_q;
        done_d       = done_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        dct_start_d  = 1'b0;
        err_d        = err_q;

        // Fill and release touch different banks, so both can apply at once.
        bank_full_d = (bank_full_q & ~clr_mask_c) | set_mask_c;

        if (xfer_c) begin
            wr_addr_d = last_c ? '0 : wr_addr_q + ADDR_W'(1);
        end
        if (last_c) begin
            wr_bank_d = ~wr_bank_q;
            loaded_d  = loaded_q + BLK_W'(1);
        end

        case (dstate_q)
            D_IDLE: begin
                if (run_c && bank_full_q[rd_bank_q] && dct_ready) begin
                    dct_start_d = 1'b1;
                    dstate_d    = D_WAIT;
                end
            end
            D_WAIT: begin
                if (rel_c) begin
                    rd_bank_d = ~rd_bank_q;
                    done_d    = done_inc_c;
                    dstate_d  = D_IDLE;
                    if (done_inc_c == cfg_q) begin
                        frame_done_d = 1'b1;
                        frame_d      = F_IDLE;
                    end
                end
            end
            default: dstate_d = D_IDLE;
        endcase

        // A done that does not close an outstanding start is only flagged.
        if (dct_done && !rel_c) begin
            err_d = 1'b1;
        end

        // Frame start; nothing else is active while idle, so overrides are safe.
        if ((frame_q == F_IDLE) && frame_go) begin
            cfg_d     = cfg_blocks;
            loaded_d  = '0;
            done_d    = '0;
            wr_addr_d = '0;
            if (cfg_blocks == '0) begin
                frame_done_d = 1'b1;
            end else begin
                frame_d = F_RUN;
            end
        end
    end

    // State registers with asynchronous reset; a mid-frame reset discards partial loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q      <= F_IDLE;
            dstate_q     <= D_IDLE;
            cfg_q        <= '0;
            loaded_q     <= '0;
            done_q       <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_addr_q    <= '0;
            bank_full_q  <= 2'b00;
            frame_done_q <= 1'b0;
            dct_start_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            frame_q      <= frame_d;
            dstate_q     <= dstate_d;
            cfg_q        <= cfg_d;
            loaded_q     <= loaded_d;
            done_q       <= done_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_addr_q    <= wr_addr_d;
            bank_full_q  <= bank_full_d;
            frame_done_q <= frame_done_d;
            dct_start_q  <= dct_start_d;
            err_q        <= err_d;
        end
    end

    assign frame_busy        = run_c;
    assign frame_done        = frame_done_q;
    assign ld_ready          = ld_ready_c;
    assign buf_wr_en         = xfer_c;
    assign buf_wr_bank       = wr_bank_q;
    assign buf_wr_addr       = wr_addr_q;
    assign buf_wr_data       = xfer_c ? ld_data : '0;
    assign dct_rd_bank       = rd_bank_q;
    assign dct_start         = dct_start_q;
    assign bank_full         = bank_full_q;
    assign blk_done_cnt      = done_q;
    assign err_spurious_done = err_q;

endmodule

// File: tb/tb_dct_block_sched.sv
// Directed testbench for dct_block_sched.
module tb_dct_block_sched;

    localparam int BPP    = 8;
    localparam int N      = 8;
    localparam int ADDR_W = 6;
    localparam int BLK_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [BLK_W-1:0]  cfg_blocks;
    logic              frame_go;
    logic              frame_busy;
    logic              frame_done;
    logic              ld_valid;
    logic [BPP-1:0]    ld_data;
    logic              ld_ready;
    logic              buf_wr_en;
    logic              buf_wr_bank;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [BPP-1:0]    buf_wr_data;
    logic              dct_rd_bank;
    logic              dct_start;
    logic              dct_ready;
    logic              dct_done;
    logic [1:0]        bank_full;
    logic [BLK_W-1:0]  blk_done_cnt;
    logic              err_spurious_done;

    int checks = 0;
    int errors = 0;

    int   tmr;
    int   nstarts;
    int   extra;
    int   xfers;
    int   cyc;
    logic stall;
    logic got;
    logic busy_at;
    logic [BLK_W-1:0] blk_at;
    logic starts [8];

    always #5 clk = ~clk;

    dct_block_sched #(
        .BPP(BPP), .N(N), .ADDR_W(ADDR_W), .BLK_W(BLK_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_blocks(cfg_blocks), .frame_go(frame_go),
        .frame_busy(frame_busy), .frame_done(frame_done),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .buf_wr_en(buf_wr_en), .buf_wr_bank(buf_wr_bank),
        .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .dct_rd_bank(dct_rd_bank), .dct_start(dct_start),
        .dct_ready(dct_ready), .dct_done(dct_done),
        .bank_full(bank_full), .blk_done_cnt(blk_done_cnt),
        .err_spurious_done(err_spurious_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
    endtask

    initial begin
        rst = 1'b1; cfg_blocks = 16'd5; frame_go = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hAA; dct_ready = 1'b1; dct_done = 1'b0;
        tick(); tick(); #2;
        check("rst_busy", frame_busy, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_ldready", ld_ready, 0);
        check("rst_wren", buf_wr_en, 0);
        check("rst_wrdata", buf_wr_data, 0);
        check("rst_wraddr", buf_wr_addr, 0);
        check("rst_start", dct_start, 0);
        check("rst_bankfull", bank_full, 0);
        check("rst_blkdone", blk_done_cnt, 0);
        check("rst_err", err_spurious_done, 0);
        check("rst_rdbank", dct_rd_bank, 0);
        ld_valid = 1'b0; ld_data = 8'h00;
        tick(); rst = 1'b0;

        // Single block frame
        cfg_blocks = 16'd1; frame_go = 1'b1; #2;
        check("t1_busy_before_go", frame_busy, 0);
        tick(); frame_go = 1'b0; #2;
        check("t1_busy", frame_busy, 1);
        check("t1_ldready", ld_ready, 1);
        for (int p = 0; p < 64; p++) begin
            ld_valid = 1'b1; ld_data = 8'(p); #2;
            check("t1_wren", buf_wr_en, 1);
            check("t1_wraddr", buf_wr_addr, p);
            check("t1_wrbank", buf_wr_bank, 0);
            check("t1_wrdata", buf_wr_data, p);
            tick();
        end
        ld_valid = 1'b0; #2;
        check("t1_bankfull_set", bank_full, 2'b01);
        check("t1_ldready_off", ld_ready, 0);
        check("t1_start_not_yet", dct_start, 0);
        tick(); #2;
        check("t1_start", dct_start, 1);
        check("t1_rdbank", dct_rd_bank, 0);
        extra = 0;
        for (int i = 1; i < 200; i++) begin
            tick(); #2;
            if (dct_start) extra++;
        end
        check("t1_single_start", extra, 0);
        tick(); dct_done = 1'b1; #2;
        check("t1_full_before_done", bank_full, 2'b01);
        check("t1_fdone_early", frame_done, 0);
        tick(); dct_done = 1'b0; #2;
        check("t1_bankfull_clr", bank_full, 2'b00);
        check("t1_blkdone", blk_done_cnt, 1);
        check("t1_fdone", frame_done, 1);
        check("t1_busy_off", frame_busy, 0);
        $display("frame cfg=1 done blk_done_cnt=%0d", blk_done_cnt);
        tick(); #2;
        check("t1_fdone_pulse", frame_done, 0);
        check("t1_err", err_spurious_done, 0);

        // Spurious done while idle
        tick(); dct_done = 1'b1; #2;
        tick(); dct_done = 1'b0; #2;
        check("sp_err", err_spurious_done, 1);
        check("sp_blkdone", blk_done_cnt, 1);
        check("sp_busy", frame_busy, 0);

        // Zero-block frame
        cfg_blocks = 16'd0; frame_go = 1'b1; ld_valid = 1'b1;
        tick(); frame_go = 1'b0; #2;
        check("z_fdone", frame_done, 1);
        check("z_busy", frame_busy, 0);
        check("z_wren", buf_wr_en, 0);
        check("z_ldready", ld_ready, 0);
        $display("frame cfg=0 done blk_done_cnt=%0d", blk_done_cnt);
        tick(); #2;
        check("z_fdone_pulse", frame_done, 0);
        check("z_err_sticky", err_spurious_done, 1);
        ld_valid = 1'b0;

        // Ping-pong, four blocks, frame_go during RUN must be ignored
        do_reset();
        check("pp_err_cleared", err_spurious_done, 0);
        cfg_blocks = 16'd4; frame_go = 1'b1;
        tick(); frame_go = 1'b0; ld_valid = 1'b1;
        tmr = 0; nstarts = 0; stall = 1'b0; got = 1'b0; cyc = 0;
        busy_at = 1'b1; blk_at = '0;
        while (!got && cyc < 2000) begin
            ld_data = 8'(cyc);
            dct_done = 1'b0;
            if (tmr > 0) begin
                tmr--;
                if (tmr == 0) dct_done = 1'b1;
            end
            frame_go   = (cyc == 100);
            cfg_blocks = (cyc == 100) ? 16'd7 : 16'd4;
            #2;
            if (dct_start) begin
                if (nstarts < 8) starts[nstarts] = dct_rd_bank;
                nstarts++;
                tmr = 150;
            end
            if (bank_full == 2'b11 && !ld_ready) stall = 1'b1;
            if (frame_done) begin
                got = 1'b1; blk_at = blk_done_cnt; busy_at = frame_busy;
            end
            cyc++;
            tick();
        end
        dct_done = 1'b0; frame_go = 1'b0; ld_valid = 1'b0;
        check("pp_frame_done_seen", got, 1);
        check("pp_nstarts", nstarts, 4);
        check("pp_bank0", starts[0], 0);
        check("pp_bank1", starts[1], 1);
        check("pp_bank2", starts[2], 0);
        check("pp_bank3", starts[3], 1);
        check("pp_stall", stall, 1);
        check("pp_blkdone", blk_at, 4);
        check("pp_busy_off", busy_at, 0);
        $display("frame cfg=4 done blk_done_cnt=%0d cycles=%0d", blk_at, cyc);

        // Simultaneous fill of bank 1 and release of bank 0
        do_reset();
        cfg_blocks = 16'd2; frame_go = 1'b1;
        tick(); frame_go = 1'b0;
        for (int p = 0; p < 64; p++) begin
            ld_valid = 1'b1; ld_data = 8'(p); tick();
        end
        ld_valid = 1'b0; #2;
        check("sim_bf_bank0", bank_full, 2'b01);
        tick(); #2;
        check("sim_start0", dct_start, 1);
        check("sim_rd0", dct_rd_bank, 0);
        for (int i = 0; i < 10; i++) tick();
        for (int p = 0; p < 63; p++) begin
            ld_valid = 1'b1; ld_data = 8'(p + 64); tick();
        end
        ld_data = 8'd127; dct_done = 1'b1; #2;
        check("sim_bf_before", bank_full, 2'b01);
        check("sim_last_wren", buf_wr_en, 1);
        check("sim_last_bank", buf_wr_bank, 1);
        check("sim_last_addr", buf_wr_addr, 63);
        tick(); ld_valid = 1'b0; dct_done = 1'b0; #2;
        check("sim_bf_swap", bank_full, 2'b10);
        check("sim_blkdone", blk_done_cnt, 1);
        check("sim_rd1", dct_rd_bank, 1);
        check("sim_ldready", ld_ready, 0);
        check("sim_no_start_yet", dct_start, 0);
        tick(); #2;
        check("sim_start1", dct_start, 1);
        check("sim_start1_bank", dct_rd_bank, 1);
        tick(); tick(); tick(); dct_done = 1'b1;
        tick(); dct_done = 1'b0; #2;
        check("sim_fdone", frame_done, 1);
        check("sim_blkdone2", blk_done_cnt, 2);
        check("sim_bf_empty", bank_full, 2'b00);
        check("sim_busy_off", frame_busy, 0);
        $display("frame cfg=2 done blk_done_cnt=%0d", blk_done_cnt);

        // Core back-pressure, then reset in the middle of the third block
        do_reset();
        dct_ready = 1'b0; cfg_blocks = 16'd3; frame_go = 1'b1;
        tick(); frame_go = 1'b0;
        xfers = 0; extra = 0;
        for (int i = 0; i < 140; i++) begin
            ld_valid = 1'b1; ld_data = 8'(i); #2;
            if (buf_wr_en) xfers++;
            if (dct_start) extra++;
            tick();
        end
        #2;
        check("bp_xfers", xfers, 128);
        check("bp_no_start", extra, 0);
        check("bp_bf", bank_full, 2'b11);
        check("bp_ldready", ld_ready, 0);
        dct_ready = 1'b1; #2;
        check("bp_start_reg", dct_start, 0);
        tick(); #2;
        check("bp_start", dct_start, 1);
        check("bp_rd0", dct_rd_bank, 0);
        check("bp_ldready_held", ld_ready, 0);
        tick(); dct_done = 1'b1;
        tick(); dct_done = 1'b0; #2;
        check("bp_bf_rel", bank_full, 2'b10);
        check("bp_ldready_back", ld_ready, 1);
        check("bp_blkdone", blk_done_cnt, 1);
        check("bp_wr_bank0", buf_wr_bank, 0);
        check("bp_wr_addr0", buf_wr_addr, 0);
        xfers = 0;
        for (int i = 0; i < 30; i++) begin
            ld_data = 8'(i + 200); #2;
            if (buf_wr_en) xfers++;
            tick();
        end
        check("rm_xfers", xfers, 30);
        check("rm_addr_before", buf_wr_addr, 30);
        rst = 1'b1; #2;
        check("rm_wren", buf_wr_en, 0);
        check("rm_wrdata", buf_wr_data, 0);
        check("rm_addr", buf_wr_addr, 0);
        check("rm_ldready", ld_ready, 0);
        check("rm_bf", bank_full, 2'b00);
        check("rm_busy", frame_busy, 0);
        check("rm_blkdone", blk_done_cnt, 0);
        check("rm_start", dct_start, 0);
        check("rm_rdbank", dct_rd_bank, 0);
        $display("reset mid-frame after %0d pixels", xfers);
        tick(); rst = 1'b0; ld_valid = 1'b0;

        // Fresh frame after the reset
        cfg_blocks = 16'd1; frame_go = 1'b1;
        tick(); frame_go = 1'b0;
        for (int p = 0; p < 64; p++) begin
            ld_valid = 1'b1; ld_data = 8'(p); #2;
            if (p == 0) begin
                check("rf_first_bank", buf_wr_bank, 0);
                check("rf_first_addr", buf_wr_addr, 0);
            end
            if (p == 63) check("rf_last_addr", buf_wr_addr, 63);
            tick();
        end
        ld_valid = 1'b0; #2;
        check("rf_bf", bank_full, 2'b01);
        tick(); #2;
        check("rf_start", dct_start, 1);
        check("rf_rd0", dct_rd_bank, 0);
        tick(); tick(); dct_done = 1'b1;
        tick(); dct_done = 1'b0; #2;
        check("rf_fdone", frame_done, 1);
        check("rf_blkdone", blk_done_cnt, 1);
        check("rf_bf_empty", bank_full, 2'b00);
        $display("frame cfg=1 done blk_done_cnt=%0d", blk_done_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
